// File: rtl/lcd_pkg.sv
// Shared constants, timing defaults and state encodings for the LCD character writer.
package lcd_pkg;

    localparam int E_SETUP_DEF    = 2;
    localparam int E_PULSE_DEF    = 12;
    localparam int NIBBLE_GAP_DEF = 50;
    localparam int CMD_WAIT_DEF   = 2000;
    localparam int CLEAR_WAIT_DEF = 82000;
    localparam int CNT_W          = 20;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] ROW1_BASE     = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR_TX,
        ST_CHAR_TX,
        ST_CLEAR_TX
    } wr_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP_HI,
        TX_PULSE_HI,
        TX_GAP,
        TX_SETUP_LO,
        TX_PULSE_LO,
        TX_WAIT
    } tx_state_t;

    function automatic logic [7:0] ddram_addr_cmd(input logic row);
        return CMD_SET_DDRAM | (row ? ROW1_BASE : 8'h00);
    endfunction

    // The column carry rolls into the row bit, and row1 col15 wraps to row0 col0.
    function automatic logic [4:0] next_cursor(input logic [4:0] cur);
        return cur + 5'd1;
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Sends one byte to the LCD as two 4-bit nibbles with E strobes, then idles for the command wait.
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int E_SETUP    = E_SETUP_DEF,
    parameter int E_PULSE    = E_PULSE_DEF,
    parameter int NIBBLE_GAP = NIBBLE_GAP_DEF,
    parameter int CMD_WAIT   = CMD_WAIT_DEF,
    parameter int CLEAR_WAIT = CLEAR_WAIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs_in,
    input  logic [7:0] byte_in,
    input  logic       long_wait,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [3:0] sf_d,
    output logic       done
);

    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(E_SETUP - 1);
    localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(E_PULSE - 1);
    localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(NIBBLE_GAP - 1);
    localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] L_CLEAR = CNT_W'(CLEAR_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    tx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_lo;
    logic             r_long;
    logic             r_rs;
    logic             r_e;
    logic [3:0]       r_sf_d;
    logic             r_done;
    logic             w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);
    assign lcd_rs     = r_rs;
    assign lcd_e      = r_e;
    assign sf_d       = r_sf_d;
    assign done       = r_done;

    // Each phase loads its length minus one and advances when the counter reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_lo    <= 4'd0;
            r_long  <= 1'b0;
            r_rs    <= 1'b0;
            r_e     <= 1'b0;
            r_sf_d  <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!w_cnt_zero) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
            case (r_state)
                TX_IDLE: begin
                    if (start) begin
                        r_state <= TX_SETUP_HI;
                        r_rs    <= rs_in;
                        r_sf_d  <= byte_in[7:4];
                        r_lo    <= byte_in[3:0];
                        r_long  <= long_wait;
                        r_cnt   <= L_SETUP;
                    end
                end
                TX_SETUP_HI: begin
                    if (w_cnt_zero) begin
                        r_state <= TX_PULSE_HI;
                        r_e     <= 1'b1;
                        r_cnt   <= L_PULSE;
                    end
                end
                TX_PULSE_HI: begin
                    if (w_cnt_zero) begin
                        r_state <= TX_GAP;
                        r_e     <= 1'b0;
                        r_cnt   <= L_GAP;
                    end
                end
                TX_GAP: begin
                    if (w_cnt_zero) begin
                        r_state <= TX_SETUP_LO;
                        r_sf_d  <= r_lo;
                        r_cnt   <= L_SETUP;
                    end
                end
                TX_SETUP_LO: begin
                    if (w_cnt_zero) begin
                        r_state <= TX_PULSE_LO;
                        r_e     <= 1'b1;
                        r_cnt   <= L_PULSE;
                    end
                end
                TX_PULSE_LO: begin
                    if (w_cnt_zero) begin
                        r_state <= TX_WAIT;
                        r_e     <= 1'b0;
                        r_sf_d  <= 4'd0;
                        r_cnt   <= r_long ? L_CLEAR : L_CMD;
                    end
                end
                TX_WAIT: begin
                    if (w_cnt_zero) begin
                        r_state <= TX_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                    r_e     <= 1'b0;
                    r_sf_d  <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_char_writer.sv
// Accepts ASCII characters after LCD configuration and writes them to DDRAM at a tracked cursor.
module lcd_char_writer
    import lcd_pkg::*;
#(
    parameter int E_SETUP    = E_SETUP_DEF,
    parameter int E_PULSE    = E_PULSE_DEF,
    parameter int NIBBLE_GAP = NIBBLE_GAP_DEF,
    parameter int CMD_WAIT   = CMD_WAIT_DEF,
    parameter int CLEAR_WAIT = CLEAR_WAIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    input  logic       clear_req,
    output logic       busy,
    output logic [4:0] cursor,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] sf_d
);

    wr_state_t  r_state;
    logic [4:0] r_cursor;
    logic [7:0] r_char;
    logic       r_start;
    logic [7:0] r_tx_byte;
    logic       r_tx_rs;
    logic       r_tx_long;
    logic       w_idle;
    logic       w_clear_go;
    logic       w_accept;
    logic       w_done;

    assign w_idle     = (r_state == ST_IDLE);
    // Clear outranks a simultaneous character; the source must keep holding it.
    assign char_ready = w_idle & enable & ~clear_req & ~rst;
    assign w_clear_go = w_idle & enable & clear_req;
    assign w_accept   = char_valid & char_ready;
    assign busy       = ~w_idle;
    assign cursor     = r_cursor;
    assign lcd_rw     = 1'b0;

    // Command sequencing: line starts get a Set-DDRAM-Address before the character.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cursor  <= 5'd0;
            r_char    <= 8'd0;
            r_start   <= 1'b0;
            r_tx_byte <= 8'd0;
            r_tx_rs   <= 1'b0;
            r_tx_long <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_clear_go) begin
                        r_state   <= ST_CLEAR_TX;
                        r_cursor  <= 5'd0;
                        r_start   <= 1'b1;
                        r_tx_byte <= CMD_CLEAR;
                        r_tx_rs   <= 1'b0;
                        r_tx_long <= 1'b1;
                    end else if (w_accept) begin
                        r_char    <= char_data;
                        r_start   <= 1'b1;
                        r_tx_long <= 1'b0;
                        if (r_cursor[3:0] == 4'd0) begin
                            r_state   <= ST_ADDR_TX;
                            r_tx_byte <= ddram_addr_cmd(r_cursor[4]);
                            r_tx_rs   <= 1'b0;
                        end else begin
                            r_state   <= ST_CHAR_TX;
                            r_tx_byte <= char_data;
                            r_tx_rs   <= 1'b1;
                        end
                    end
                end
                ST_ADDR_TX: begin
                    if (w_done) begin
                        r_state   <= ST_CHAR_TX;
                        r_start   <= 1'b1;
                        r_tx_byte <= r_char;
                        r_tx_rs   <= 1'b1;
                        r_tx_long <= 1'b0;
                    end
                end
                ST_CHAR_TX: begin
                    if (w_done) begin
                        r_state  <= ST_IDLE;
                        r_cursor <= next_cursor(r_cursor);
                    end
                end
                ST_CLEAR_TX: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    lcd_byte_tx #(
        .E_SETUP    (E_SETUP),
        .E_PULSE    (E_PULSE),
        .NIBBLE_GAP (NIBBLE_GAP),
        .CMD_WAIT   (CMD_WAIT),
        .CLEAR_WAIT (CLEAR_WAIT)
    ) u_byte_tx (
        .clk       (clk),
        .rst       (rst),
        .start     (r_start),
        .rs_in     (r_tx_rs),
        .byte_in   (r_tx_byte),
        .long_wait (r_tx_long),
        .lcd_rs    (lcd_rs),
        .lcd_e     (lcd_e),
        .sf_d      (sf_d),
        .done      (w_done)
    );

endmodule

// File: tb/tb_lcd_char_writer.sv
// Randomized bench for lcd_char_writer: a bus monitor rebuilds bytes from the E strobes and
// compares them with a byte list predicted from the cursor and command rules.
module tb_lcd_char_writer;

    localparam int S   = 2;
    localparam int P   = 12;
    localparam int G   = 50;
    localparam int CW  = 60;
    localparam int CLW = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic       clear_req;
    logic       busy;
    logic [4:0] cursor;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [3:0] sf_d;

    lcd_char_writer #(
        .E_SETUP(S), .E_PULSE(P), .NIBBLE_GAP(G), .CMD_WAIT(CW), .CLEAR_WAIT(CLW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .char_valid(char_valid),
        .char_data(char_data), .char_ready(char_ready), .clear_req(clear_req),
        .busy(busy), .cursor(cursor), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .sf_d(sf_d)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];
    logic [4:0] m_cursor;
    int         m_wait;
    int         last_fall = 0;
    int         rise_cyc = 0;
    int         launch_cyc = 0;
    bit         launch_pending = 1'b0;
    bit         half = 1'b0;
    logic       prev_e = 1'b0;
    logic [3:0] nib;
    logic [3:0] hi_nib;
    logic       hi_rs;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Bus monitor: pulse widths, nibble spacing and reassembled {rs, byte} against the prediction.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            half = 1'b0;
            exp_q.delete();
            launch_pending = 1'b0;
            prev_e = lcd_e;
        end else begin
            if (lcd_e && !prev_e) begin
                rise_cyc = cyc;
                nib = sf_d;
                check_value("lcd_rw", 32'(lcd_rw), 32'd0);
                if (!half) begin
                    hi_rs = lcd_rs;
                    if (launch_pending) begin
                        check_value("e_latency", 32'(cyc - launch_cyc), 32'(S + 1));
                        launch_pending = 1'b0;
                    end
                end else begin
                    // E low between nibbles covers the gap phase plus the low-nibble setup.
                    check_value("nibble_gap", 32'(cyc - last_fall), 32'(G + S));
                    check_value("rs_stable", 32'(lcd_rs), 32'(hi_rs));
                end
            end else if (lcd_e && prev_e) begin
                check_value("sf_d_hold", 32'(sf_d), 32'(nib));
            end else if (!lcd_e && prev_e) begin
                check_value("e_width", 32'(cyc - rise_cyc), 32'(P));
                last_fall = cyc;
                if (!half) begin
                    hi_nib = nib;
                    half = 1'b1;
                end else begin
                    half = 1'b0;
                    check_value("sf_d_wait", 32'(sf_d), 32'd0);
                    if (exp_q.size() == 0)
                        check_value("byte_extra", 32'({hi_rs, hi_nib, nib}), 32'h200);
                    else
                        check_value("byte", 32'({hi_rs, hi_nib, nib}), 32'(exp_q.pop_front()));
                end
            end
            prev_e = lcd_e;
        end
    end

    // Samples the currently driven request and predicts what the DUT does at the next edge.
    task automatic commit();
        logic       v;
        logic       clr;
        logic       exp_rdy;
        logic [7:0] d;
        v = char_valid;
        d = char_data;
        clr = clear_req;
        #1;
        exp_rdy = enable & ~clr;
        check_value("char_ready", 32'(char_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (enable && clr) begin
            m_cursor = 5'd0;
            exp_q.push_back({1'b0, 8'h01});
            launch_cyc = cyc;
            launch_pending = 1'b1;
            m_wait = CLW;
        end else if (v && exp_rdy) begin
            if (m_cursor[3:0] == 4'd0)
                exp_q.push_back({1'b0, (m_cursor[4] ? 8'hC0 : 8'h80)});
            exp_q.push_back({1'b1, d});
            m_cursor = (m_cursor == 5'd31) ? 5'd0 : m_cursor + 5'd1;
            launch_cyc = cyc;
            launch_pending = 1'b1;
            m_wait = CW;
            char_valid = 1'b0;
        end
        clear_req = 1'b0;
    endtask

    task automatic present(input logic v, input logic [7:0] d, input logic clr);
        @(negedge clk);
        char_valid = v;
        char_data = d;
        clear_req = clr;
        commit();
    endtask

    task automatic wait_idle();
        int n;
        int tail;
        bit fin;
        bit sure_busy;
        n = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            #1;
            sure_busy = (exp_q.size() != 0) || half || (cyc < last_fall + m_wait);
            if (sure_busy) begin
                check_value("busy_hold", 32'(busy), 32'd1);
                check_value("ready_while_busy", 32'(char_ready), 32'd0);
            end else if (!busy) begin
                fin = 1'b1;
            end
            n++;
            if (!fin && n > 4 * CLW + 2000) begin
                check_value("idle_timeout", 32'(busy), 32'd0);
                fin = 1'b1;
            end
        end
        tail = cyc - last_fall;
        check_value("queue_drained", 32'(exp_q.size()), 32'd0);
        check_value("busy_tail_min", 32'(tail >= m_wait), 32'd1);
        check_value("busy_tail_max", 32'(tail <= m_wait + 2), 32'd1);
        check_value("cursor", 32'(cursor), 32'(m_cursor));
    endtask

    task automatic disabled_window(input int n);
        enable = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            char_valid = 1'b1;
            char_data = 8'($urandom);
            clear_req = ($urandom_range(0, 3) == 0);
            #1;
            check_value("ready_disabled", 32'(char_ready), 32'd0);
            check_value("e_disabled", 32'(lcd_e), 32'd0);
            check_value("busy_disabled", 32'(busy), 32'd0);
        end
        @(negedge clk);
        char_valid = 1'b0;
        clear_req = 1'b0;
        check_value("cursor_disabled", 32'(cursor), 32'(m_cursor));
    endtask

    initial begin
        logic [7:0] c;
        int n;
        rst = 1'b1;
        enable = 1'b0;
        char_valid = 1'b0;
        clear_req = 1'b0;
        char_data = 8'd0;
        m_cursor = 5'd0;
        m_wait = CW;
        repeat (3) @(negedge clk);
        #1;
        check_value("rst_lcd_e", 32'(lcd_e), 32'd0);
        check_value("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        check_value("rst_lcd_rw", 32'(lcd_rw), 32'd0);
        check_value("rst_sf_d", 32'(sf_d), 32'd0);
        check_value("rst_cursor", 32'(cursor), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_ready", 32'(char_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;

        // 'A' from home: 0x80 address then the character.
        present(1'b1, 8'h41, 1'b0);
        wait_idle();

        // Clear together with a character: clear wins, character is held and taken afterwards.
        c = 8'($urandom_range(33, 126));
        present(1'b1, c, 1'b1);
        wait_idle();
        commit();
        wait_idle();

        present(1'b0, 8'h00, 1'b1);
        wait_idle();

        // 33 characters from home cover the row change at 16 and the wrap at 32.
        for (int i = 0; i < 33; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            present(1'b1, 8'($urandom_range(32, 126)), 1'b0);
            wait_idle();
        end

        disabled_window(20);
        enable = 1'b1;

        // Drop enable partway through a character write; the write must still finish.
        present(1'b1, 8'($urandom_range(32, 126)), 1'b0);
        repeat ($urandom_range(5, 100)) @(negedge clk);
        enable = 1'b0;
        wait_idle();
        disabled_window(5);
        enable = 1'b1;

        // Reset while E is high on the first nibble.
        present(1'b1, 8'($urandom_range(32, 126)), 1'b0);
        n = 0;
        while (lcd_e !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_value("e_seen_before_rst", 32'(lcd_e), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_cursor = 5'd0;
        check_value("midrst_lcd_e", 32'(lcd_e), 32'd0);
        check_value("midrst_sf_d", 32'(sf_d), 32'd0);
        check_value("midrst_lcd_rs", 32'(lcd_rs), 32'd0);
        check_value("midrst_busy", 32'(busy), 32'd0);
        check_value("midrst_cursor", 32'(cursor), 32'd0);
        check_value("midrst_ready", 32'(char_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        present(1'b1, 8'($urandom_range(32, 126)), 1'b0);
        wait_idle();

        // Short random mix of characters and clears.
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 4) == 0)
                present(1'b0, 8'h00, 1'b1);
            else
                present(1'b1, 8'($urandom_range(32, 126)), 1'b0);
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_char_writer.md
Name: lcd_char_writer

Overview:
- Display-write stage directly downstream of the power-on/configuration stage for the Spartan-3E 16x2 character LCD (4-bit SF_D interface, 50 MHz clk).
- Once configuration has completed, it accepts ASCII characters over a valid/ready handshake and writes them to DDRAM at a tracked cursor position.
- It issues Set-DDRAM-Address commands automatically at line starts and supports a clear-display request.
- Its LCD outputs are muxed onto the pins by the top level whenever the init stage is inactive.

Parameters:
- E_SETUP, 2, cycles data/rs are stable before lcd_e rises (≥40 ns)
- E_PULSE, 12, cycles lcd_e is held high (≥230 ns)
- NIBBLE_GAP, 50, cycles between the upper-nibble and lower-nibble pulses (≥1 us)
- CMD_WAIT, 2000, cycles of idle after each byte (≥40 us)
- CLEAR_WAIT, 82000, cycles of idle after the clear command (≥1.64 ms)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- enable  in  1  high once LCD configuration is complete; gates acceptance of new work
- char_valid  in  1  char_data is valid
- char_data  in  8  ASCII code to display
- char_ready  out  1  writer accepts char_data this cycle
- clear_req  in  1  single-cycle request to clear the display and home the cursor
- busy  out  1  high whenever the writer is not IDLE
- cursor  out  5  current position; bit4 = row, bits3:0 = column
- lcd_rs  out  1  register select: 1 = data, 0 = command
- lcd_rw  out  1  always 0 (write only)
- lcd_e  out  1  enable strobe
- sf_d  out  4  data nibble, sf_d[3:0] = SF_D<11:8>

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State returns to IDLE.
  - lcd_e, lcd_rs, lcd_rw = 0; sf_d = 0; cursor = 0; busy = 0; char_ready = 0.
  - Reset applied mid-transfer drops lcd_e low on that edge. Any byte in progress is abandoned.
- char_ready = (state==IDLE) & enable & ~clear_req. This is combinational from state and inputs.
- Accept: char_valid & char_ready at an edge captures char_data.
- Clear priority: clear_req & (state==IDLE) & enable at an edge starts a clear.
  - Clear wins over a simultaneous char_valid. The character is not accepted and must be held by the source.
  - clear_req outside IDLE, or with enable low, is ignored (dropped).
- Byte transfer sequence: SETUP_HI(E_SETUP) -> PULSE_HI(E_PULSE, lcd_e=1) -> GAP(NIBBLE_GAP, lcd_e=0) -> SETUP_LO(E_SETUP) -> PULSE_LO(E_PULSE) -> WAIT(CMD_WAIT or CLEAR_WAIT).
  - sf_d carries byte[7:4] from SETUP_HI through GAP, and byte[3:0] from SETUP_LO through the end of PULSE_LO.
  - sf_d returns to 0 in WAIT.
  - lcd_rs is stable for the whole transfer.
- Latency: lcd_e first rises E_SETUP+1 cycles after the accepting edge.
- Top-level FSM states: IDLE, ADDR_TX, CHAR_TX, CLEAR_TX.
  - Accept with cursor column==0 -> ADDR_TX. This sends command 0x80 | (row ? 0x40 : 0x00) with rs=0, then goes to CHAR_TX.
  - Accept with column!=0 -> CHAR_TX directly. This sends the captured char with rs=1.
  - CHAR_TX done -> cursor advances -> IDLE.
  - Clear -> CLEAR_TX. This sends 0x01 with rs=0 and waits CLEAR_WAIT; cursor is set to 0 on entry. When done -> IDLE.
- Cursor advance rules:
  - col 0..14: col+1.
  - row0 col15: row1 col0.
  - row1 col15: row0 col0 (wrap to top).
- enable falling mid-transfer: the current operation completes (including any pending CHAR_TX after ADDR_TX); only new acceptance is blocked.
- Counter: a single down/up counter wide enough for CLEAR_WAIT (17 bits minimum; use 20).

Decomposition:
- Package lcd_pkg holds:
  - the LCD command constants CMD_CLEAR=0x01, CMD_SET_DDRAM=0x80, ROW1_BASE=0x40;
  - the timing defaults;
  - the state enumerations.
- One sub-module, lcd_byte_tx:
  - ports: start, rs_in, byte_in, long_wait → lcd_rs/lcd_e/sf_d, done.
  - It owns the nibble state machine and timing counter.
  - lcd_char_writer owns the handshake, the command sequencing and the cursor.

Test Plan:
- Reset, enable=1, send 'A' (0x41) -> ADDR_TX sends 0x80 with rs=0, nibbles 0x8 then 0x0.
  - Then CHAR_TX with rs=1, nibbles 0x4 then 0x1.
  - Each E pulse is exactly 12 cycles high and the nibble gap is 50 cycles.
  - Afterwards cursor=0x01.
- Send 16 chars starting at cursor 0 -> the 17th char is preceded by command 0xC0; cursor=0x11 after it.
- Write 32 chars -> cursor wraps to 0x00; the 33rd char is preceded by 0x80.
- clear_req and char_valid asserted in the same IDLE cycle -> 0x01 is sent, char_ready=0 that cycle, busy is held for CLEAR_WAIT after the pulse, cursor=0, and the char is accepted afterwards.
- enable=0 with char_valid=1 -> char_ready=0 and no lcd_e activity.
  - Deassert enable mid-CHAR_TX -> the byte completes normally.
- Assert rst during PULSE_HI -> lcd_e=0 on the next edge, all outputs reach reset values, cursor=0, and a subsequent char restarts with an address command.
